// File: rtl/rainbow_pkg.sv
// Shared definitions for the rainbow LED scheduler: colour wheel and FSM states.
package rainbow_pkg;

  // Active-low {red, blue, green} LED codes
  localparam logic [2:0] RED     = 3'b011;
  localparam logic [2:0] YELLOW  = 3'b010;
  localparam logic [2:0] GREEN   = 3'b110;
  localparam logic [2:0] CYAN    = 3'b100;
  localparam logic [2:0] BLUE    = 3'b101;
  localparam logic [2:0] MAGENTA = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b111;

  localparam int unsigned WHEEL_LEN  = 6;
  localparam logic [2:0]  WHEEL_LAST = 3'(WHEEL_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  // Colour at a wheel position; out-of-range indices show LED off
  function automatic logic [2:0] wheel_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = RED;
      3'd1:    c = YELLOW;
      3'd2:    c = GREEN;
      3'd3:    c = CYAN;
      3'd4:    c = BLUE;
      3'd5:    c = MAGENTA;
      default: c = LED_OFF;
    endcase
    return c;
  endfunction

  // Next wheel position, modulo WHEEL_LEN
  function automatic logic [2:0] wheel_next(input logic [2:0] idx);
    return (idx == WHEEL_LAST) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rainbow_scheduler_slot_tick_gen.sv
// Dither slot divider: pulses slot_tick on the last clock of every slot.
module slot_tick_gen #(
  parameter int unsigned TICKS_PER_SLOT = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic slot_tick
);

  localparam int unsigned TICK_W = (TICKS_PER_SLOT > 1) ? $clog2(TICKS_PER_SLOT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SLOT - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  // Free-running count while run is high; held at zero otherwise
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    slot_tick  = 1'b0;
    if (!run) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      slot_tick  = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Tick counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/rainbow_scheduler.sv
// Rainbow LED scheduler: walks a 6-hue wheel, blending each hue pair by
// time-dithering past and future colours within every blur window.
module rainbow_scheduler
  import rainbow_pkg::*;
#(
  parameter int unsigned TICKS_PER_SLOT   = 12000,
  parameter int unsigned SLOTS_PER_WINDOW = 32,
  parameter int unsigned WINDOWS_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  output logic [2:0] led,
  output logic [2:0] base_idx,
  output logic       wrap
);

  localparam int unsigned SLOT_W = (SLOTS_PER_WINDOW > 1) ? $clog2(SLOTS_PER_WINDOW) : 1;
  localparam int unsigned WIN_W  = (WINDOWS_PER_STEP > 1) ? $clog2(WINDOWS_PER_STEP) : 1;
  localparam int unsigned PW_W   = $clog2(SLOTS_PER_WINDOW + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_WINDOW - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOWS_PER_STEP - 1);
  localparam logic [PW_W-1:0]   PW_FULL   = PW_W'(SLOTS_PER_WINDOW);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [SLOT_W-1:0] step_idx_q, step_idx_d;
  logic [2:0]        base_idx_q, base_idx_d;
  logic [PW_W-1:0]   p_weight_q, p_weight_d;
  logic [2:0]        p_color_q, p_color_d;
  logic [2:0]        f_color_q, f_color_d;
  logic [2:0]        led_q, led_d;
  logic              wrap_q, wrap_d;

  logic run;
  logic slot_tick;
  logic window_end;
  logic advance;

  // Counters run only while active and enabled, so dropping en clears them on the same edge
  always_comb begin
    run = (state_q != ST_IDLE) && en;
  end

  slot_tick_gen #(
    .TICKS_PER_SLOT(TICKS_PER_SLOT)
  ) u_slot_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .slot_tick(slot_tick)
  );

  // FSM next state, blend counters, window-end latching and LED selection
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    win_cnt_d  = win_cnt_q;
    step_idx_d = step_idx_q;
    base_idx_d = base_idx_q;
    p_weight_d = p_weight_q;
    p_color_d  = p_color_q;
    f_color_d  = f_color_q;
    led_d      = LED_OFF;
    wrap_d     = 1'b0;

    window_end = slot_tick && (slot_cnt_q == SLOT_LAST);
    // Progress happens at any window end where hold is low, so the window that
    // samples hold=1 repeats its step and the window that samples hold=0 advances.
    advance    = run && window_end && !hold;

    if (!run) begin
      slot_cnt_d = '0;
      win_cnt_d  = '0;
    end else if (slot_tick) begin
      slot_cnt_d = window_end ? '0 : slot_cnt_q + SLOT_W'(1);
    end

    if (advance) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d = '0;
        if (step_idx_q == SLOT_LAST) begin
          step_idx_d = '0;
          base_idx_d = wheel_next(base_idx_q);
          wrap_d     = (base_idx_q == WHEEL_LAST);
        end else begin
          step_idx_d = step_idx_q + SLOT_W'(1);
        end
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (!en) state_d = ST_IDLE;
        else if (window_end && hold) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en) state_d = ST_IDLE;
        else if (window_end && !hold) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // IDLE keeps the blend registers tracking the retained hue pair so a
    // restart shows the right colours from slot 0 without waiting a window.
    if ((state_q == ST_IDLE) || window_end) begin
      p_weight_d = PW_FULL - PW_W'(step_idx_d);
      p_color_d  = wheel_color(base_idx_d);
      f_color_d  = wheel_color(wheel_next(base_idx_d));
    end

    if (run) begin
      led_d = (PW_W'(slot_cnt_q) < p_weight_q) ? p_color_q : f_color_q;
    end
  end

  // State, counters, blend and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= '0;
      win_cnt_q  <= '0;
      step_idx_q <= '0;
      base_idx_q <= '0;
      p_weight_q <= PW_FULL;
      p_color_q  <= RED;
      f_color_q  <= YELLOW;
      led_q      <= LED_OFF;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      win_cnt_q  <= win_cnt_d;
      step_idx_q <= step_idx_d;
      base_idx_q <= base_idx_d;
      p_weight_q <= p_weight_d;
      p_color_q  <= p_color_d;
      f_color_q  <= f_color_d;
      led_q      <= led_d;
      wrap_q     <= wrap_d;
    end
  end

  // Output drive
  always_comb begin
    led      = led_q;
    base_idx = base_idx_q;
    wrap     = wrap_q;
  end

endmodule

// File: tb/tb_rainbow_scheduler.sv
// Self-checking bench for rainbow_scheduler with a window-position reference model.
module tb_rainbow_scheduler;

  localparam int T = 2;
  localparam int S = 4;
  localparam int W = 1;
  localparam int WIN_CYC = T * S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] led;
  logic [2:0] base_idx;
  logic       wrap;

  int total = 0;
  int bad = 0;

  rainbow_scheduler #(
    .TICKS_PER_SLOT  (T),
    .SLOTS_PER_WINDOW(S),
    .WINDOWS_PER_STEP(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .hold    (hold),
    .led     (led),
    .base_idx(base_idx),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: position in window (cycles), windows into step, step, hue,
  // plus the step/hue snapshot being displayed in the current window.
  logic [2:0] wheel_tb [6];
  int m_active, m_pos, m_win, m_step, m_base, d_step, d_base;
  logic [2:0] exp_led;
  logic       exp_wrap;
  logic [2:0] exp_base;

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_win = 0; m_step = 0; m_base = 0;
    d_step = 0; d_base = 0;
    exp_led = 3'b111; exp_wrap = 1'b0; exp_base = 3'd0;
  endtask

  // Advance the model over one clock edge using the current inputs, then clock the DUT
  task automatic tick();
    logic [2:0] led_n;
    logic       wrap_n;
    led_n = 3'b111;
    wrap_n = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_active == 0) begin
      d_step = m_step; d_base = m_base;
      if (en) begin m_active = 1; m_pos = 0; m_win = 0; end
    end else if (!en) begin
      m_active = 0; m_pos = 0; m_win = 0;
    end else begin
      led_n = ((m_pos / T) < (S - d_step)) ? wheel_tb[d_base] : wheel_tb[(d_base + 1) % 6];
      if (m_pos == WIN_CYC - 1) begin
        m_pos = 0;
        if (!hold) begin
          m_win++;
          if (m_win == W) begin
            m_win = 0;
            m_step++;
            if (m_step == S) begin
              m_step = 0;
              m_base = (m_base + 1) % 6;
              wrap_n = (m_base == 0);
            end
          end
        end
        d_step = m_step; d_base = m_base;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    exp_led = led_n;
    exp_wrap = wrap_n;
    exp_base = 3'(m_base);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (led !== 3'b111 || base_idx !== 3'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got led=%b base=%0d wrap=%b want led=111 base=0 wrap=0", led, base_idx, wrap);
    end
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (led !== 3'b111 || base_idx !== 3'd0 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL idle_off cyc=%0d got led=%b base=%0d wrap=%b want led=111 base=0 wrap=0", i, led, base_idx, wrap);
      end
    end
  endtask

  task automatic test_first_windows();
    logic [2:0] want;
    en = 1'b1;
    for (int i = 0; i <= 2 * WIN_CYC; i++) begin
      tick();
      want = (i == 0) ? 3'b111 : ((i <= 14) ? 3'b011 : 3'b010);
      total++;
      if (led !== want) begin
        bad++;
        $display("FAIL first_windows cyc=%0d got led=%b want %b", i, led, want);
      end
      total++;
      if (led !== exp_led) begin
        bad++;
        $display("FAIL first_windows_model cyc=%0d got led=%b want %b", i, led, exp_led);
      end
    end
  endtask

  task automatic test_revolution();
    int wraps = 0;
    int changes = 0;
    logic [2:0] prev;
    logic [2:0] want_next;
    prev = base_idx;
    for (int i = 0; i < 6 * S * W * WIN_CYC; i++) begin
      tick();
      total++;
      if (led !== exp_led || base_idx !== exp_base || wrap !== exp_wrap) begin
        bad++;
        $display("FAIL revolution cyc=%0d got led=%b base=%0d wrap=%b want led=%b base=%0d wrap=%b",
                 i, led, base_idx, wrap, exp_led, exp_base, exp_wrap);
      end
      if (wrap === 1'b1) wraps++;
      if (base_idx !== prev) begin
        changes++;
        want_next = (prev == 3'd5) ? 3'd0 : prev + 3'd1;
        total++;
        if (base_idx !== want_next) begin
          bad++;
          $display("FAIL base_sequence got %0d want %0d", base_idx, want_next);
        end
        prev = base_idx;
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL wrap_count got %0d want 1", wraps);
    end
    total++;
    if (changes != 6) begin
      bad++;
      $display("FAIL base_changes got %0d want 6", changes);
    end
  endtask

  task automatic test_hold();
    int nh, red_cnt, yel_cnt, guard, pre;
    // step is 2 here; assert hold partway into its window
    pre = 1 + int'($urandom % 6);
    for (int i = 0; i < pre; i++) tick();
    hold = 1'b1;
    guard = 0;
    do begin
      tick(); guard++;
      total++;
      if (led !== exp_led) begin
        bad++;
        $display("FAIL hold_finish got led=%b want %b", led, exp_led);
      end
    end while (m_pos != 0 && guard < 4 * WIN_CYC);
    if (m_pos != 0) begin
      total++; bad++;
      $display("FAIL hold_window_timeout got pos=%0d want 0", m_pos);
    end
    nh = 2 + int'($urandom % 2);
    red_cnt = 0; yel_cnt = 0;
    for (int i = 0; i < nh * WIN_CYC; i++) begin
      tick();
      if (led === 3'b011) red_cnt++;
      if (led === 3'b010) yel_cnt++;
      total++;
      if (led !== exp_led || base_idx !== 3'd0) begin
        bad++;
        $display("FAIL hold_repeat got led=%b base=%0d want led=%b base=0", led, base_idx, exp_led);
      end
    end
    total++;
    if (red_cnt != 4 * nh || yel_cnt != 4 * nh) begin
      bad++;
      $display("FAIL hold_split got red=%0d yel=%0d want %0d each", red_cnt, yel_cnt, 4 * nh);
    end
    pre = 1 + int'($urandom % 6);
    for (int i = 0; i < pre; i++) tick();
    hold = 1'b0;
    guard = 0;
    do begin
      tick(); guard++;
    end while (m_pos != 0 && guard < 4 * WIN_CYC);
    red_cnt = 0; yel_cnt = 0;
    for (int i = 0; i < WIN_CYC; i++) begin
      tick();
      if (led === 3'b011) red_cnt++;
      if (led === 3'b010) yel_cnt++;
      total++;
      if (led !== exp_led) begin
        bad++;
        $display("FAIL hold_release got led=%b want %b", led, exp_led);
      end
    end
    total++;
    if (red_cnt != 2 || yel_cnt != 6) begin
      bad++;
      $display("FAIL step3_split got red=%0d yel=%0d want red=2 yel=6", red_cnt, yel_cnt);
    end
  endtask

  task automatic test_en_drop();
    int guard, pre, idle_n;
    guard = 0;
    while (m_base != 3 && guard < 400) begin
      tick(); guard++;
      total++;
      if (led !== exp_led || base_idx !== exp_base || wrap !== exp_wrap) begin
        bad++;
        $display("FAIL run_to_cyan got led=%b base=%0d wrap=%b want led=%b base=%0d wrap=%b",
                 led, base_idx, wrap, exp_led, exp_base, exp_wrap);
      end
    end
    if (m_base != 3) begin
      total++; bad++;
      $display("FAIL cyan_timeout got base=%0d want 3", m_base);
    end
    pre = 1 + int'($urandom % 6);
    for (int i = 0; i < pre; i++) tick();
    en = 1'b0;
    tick();
    total++;
    if (led !== 3'b111 || base_idx !== 3'd3) begin
      bad++;
      $display("FAIL en_drop got led=%b base=%0d want led=111 base=3", led, base_idx);
    end
    idle_n = 3 + int'($urandom % 8);
    for (int i = 0; i < idle_n; i++) begin
      tick();
      total++;
      if (led !== 3'b111) begin
        bad++;
        $display("FAIL idle_after_drop got led=%b want 111", led);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2 * WIN_CYC + 1; i++) begin
      tick();
      total++;
      if (led !== exp_led || base_idx !== 3'd3) begin
        bad++;
        $display("FAIL resume cyc=%0d got led=%b base=%0d want led=%b base=3", i, led, base_idx, exp_led);
      end
    end
  endtask

  task automatic test_async_reset();
    int dly;
    dly = 1 + int'($urandom % 3);
    #(dly);
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 3'b111 || base_idx !== 3'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got led=%b base=%0d wrap=%b want led=111 base=0 wrap=0", led, base_idx, wrap);
    end
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * WIN_CYC; i++) begin
      tick();
      total++;
      if (led !== exp_led || base_idx !== exp_base || wrap !== exp_wrap) begin
        bad++;
        $display("FAIL restart cyc=%0d got led=%b base=%0d wrap=%b want led=%b base=%0d wrap=%b",
                 i, led, base_idx, wrap, exp_led, exp_base, exp_wrap);
      end
    end
  endtask

  initial begin
    wheel_tb[0] = 3'b011; wheel_tb[1] = 3'b010; wheel_tb[2] = 3'b110;
    wheel_tb[3] = 3'b100; wheel_tb[4] = 3'b101; wheel_tb[5] = 3'b001;
    model_reset();
    test_reset();
    test_first_windows();
    test_revolution();
    test_hold();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
